// File: rtl/dmem_if.sv
`timescale 1ns/1ps
// dmem_if: load/store request/response bus between the core (master) and dmem_responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// dmem_responder: fixed-latency data memory behind the core's load/store port.
// One request per handshake, serviced LATENCY edges after acceptance, answered
// with a one-cycle rsp_valid pulse. stall is high while an access is in flight.
// Optional macro DMEM_STALL_CNT_EN adds a saturating stall-cycle counter port.
module dmem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned LATENCY   = 2,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    dmem_if.slave       bus,
    output logic        stall
`ifdef DMEM_STALL_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned     CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [31:0]      rsp_rdata_q;

    logic              addr_err_c;
    logic              access_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] idx_c;
    logic [31:0]       mem_q_c;

    // Decode of the captured request: error check, word index, access strobe.
    assign addr_err_c = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign idx_c      = addr_q[ADDR_W+1:2];
    assign access_c   = (state == BUSY) && (cnt == '0);
    assign mem_we_c   = access_c && we_q && !addr_err_c;

    // Word array; the zero-init flavour clears contents at power-up, never on reset.
    if (INIT_ZERO) begin : g_mem_zero
        logic [31:0] mem [DEPTH] = '{default: 32'h0};

        // Write port, committed only at the access edge of a legal write.
        always_ff @(posedge clk) begin
            if (mem_we_c) mem[idx_c] <= wdata_q;
        end
        assign mem_q_c = mem[idx_c];
    end else begin : g_mem_undef
        logic [31:0] mem [DEPTH];

        // Write port, committed only at the access edge of a legal write.
        always_ff @(posedge clk) begin
            if (mem_we_c) mem[idx_c] <= wdata_q;
        end
        assign mem_q_c = mem[idx_c];
    end

    // Request/response FSM with registered handshake, stall and response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            stall       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        cnt         <= CNT_LOAD;
                        req_ready_q <= 1'b0;
                        stall       <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= addr_err_c;
                        rsp_rdata_q <= (we_q || addr_err_c) ? 32'h0 : mem_q_c;
                        req_ready_q <= 1'b1;
                        stall       <= 1'b0;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        cnt         <= CNT_LOAD;
                        req_ready_q <= 1'b0;
                        stall       <= 1'b1;
                        state       <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    stall       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DMEM_STALL_CNT_EN
    // Saturating count of edges that see an access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= 32'h0;
        end else if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// tb_dmem_responder: scoreboard bench; expected responses queued at request time,
// popped and compared by a response monitor, plus per-scenario timing checks.
module tb_dmem_responder;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic stall;
`ifdef DMEM_STALL_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    dmem_if bus ();

    dmem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .stall          (stall)
`ifdef DMEM_STALL_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && bus.rsp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
                    errors++;
                    $display("FAIL rsp_data: got err=%b rdata=%h want err=%b rdata=%h",
                             bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
                end
            end
        end
    end

    // Drive one request, hold it until accepted, queue its expected response.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 want 1 within 50 cycles");
        end
        sb_q.push_back('{err: exp_err, rdata: exp_rdata});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Count edges from acceptance until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        checks++;
        if (!bus.rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid want rsp_valid within 20 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_write_read();
        int lat;
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        wait_rsp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL write_latency: got %0d want 2", lat); end
        send(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_rsp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL read_latency: got %0d want 2", lat); end
        repeat (2) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL pulse_width: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdata_hold: got %h want deadbeef", bus.rsp_rdata); end
    endtask

    task automatic test_misaligned();
        int lat;
        send(1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
        wait_rsp(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL err_latency: got %0d want 2", lat); end
        send(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_rsp(lat);
    endtask

    task automatic test_out_of_range();
        int lat;
        send(1'b1, 32'h400, 32'h55AA_55AA, 1'b1, 32'h0);
        wait_rsp(lat);
        send(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        wait_rsp(lat);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        int acc = 0, nstall = 0, nrsp = 0, last = -1, bad_gap = 0, bad_overlap = 0;
        addrs[0] = 32'h10; addrs[1] = 32'h0; addrs[2] = 32'h10;
        sb_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
        sb_q.push_back('{err: 1'b0, rdata: 32'h0});
        sb_q.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_wdata = 32'h0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (acc == 3) bus.req_valid = 1'b0;
            else bus.req_addr = addrs[acc];
            if (stall) nstall++;
            if (stall && bus.req_ready) bad_overlap++;
            if (bus.rsp_valid) begin
                if (last >= 0 && c - last != 3) bad_gap++;
                last = c;
                nrsp++;
            end
            if (bus.req_valid && bus.req_ready) acc++;
        end
        checks++; if (acc != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
        checks++; if (nrsp != 3) begin errors++; $display("FAIL b2b_rsp_count: got %0d want 3", nrsp); end
        checks++; if (nstall != 6) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want 6", nstall); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_period: got %0d bad gaps want 0", bad_gap); end
        checks++; if (bad_overlap != 0) begin errors++; $display("FAIL b2b_ready_in_busy: got %0d want 0", bad_overlap); end
    endtask

    task automatic test_reset_mid_op();
        int lat, nrsp = 0;
        send(1'b1, 32'h20, 32'hCAFE_0001, 1'b0, 32'h0);
        wait_rsp(lat);
        send(1'b1, 32'h20, 32'h0000_1234, 1'b0, 32'h0);
        void'(sb_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", stall); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.req_ready); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
        end
        checks++; if (nrsp != 0) begin errors++; $display("FAIL midrst_no_rsp: got %0d responses want 0", nrsp); end
        send(1'b0, 32'h20, 32'h0, 1'b0, 32'hCAFE_0001);
        wait_rsp(lat);
    endtask

`ifdef DMEM_STALL_CNT_EN
    task automatic test_stall_cnt();
        int lat;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", perf_stall_cnt); end
        reset = 1'b1;
        send(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
        wait_rsp(lat);
        send(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        wait_rsp(lat);
        @(negedge clk);
        checks++; if (perf_stall_cnt !== 32'd4) begin errors++; $display("FAIL cnt_two_reads: got %0d want 4", perf_stall_cnt); end
        reset = 1'b0;
        #1;
        checks++; if (perf_stall_cnt !== 32'h0) begin errors++; $display("FAIL cnt_rereset: got %0d want 0", perf_stall_cnt); end
        @(negedge clk);
        reset = 1'b1;
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
`ifdef DMEM_STALL_CNT_EN
        test_stall_cnt();
`endif
        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
